// File: rtl/seq_arbiter.sv
// seq_arbiter: round-robin front end for one shared wide-to-narrow serializer.
// Takes one wide word from the winning requester, drives the serializer load
// handshake, then watches the serializer's busy window and counts beats until
// the word has been fully emitted. Reports completion and sticky protocol errors.
module seq_arbiter #(
    parameter int unsigned NUM_REQ           = 4,
    parameter int unsigned DATA_INPUT_WIDTH  = 256,
    parameter int unsigned DATA_OUTPUT_WIDTH = 32,
    parameter int unsigned LOAD_TIMEOUT      = 16
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    input  logic [NUM_REQ*DATA_INPUT_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    output logic                                ser_valid_o,
    output logic [DATA_INPUT_WIDTH-1:0]         ser_data_o,
    input  logic                                ser_accepted_i,
    input  logic                                ser_busy_i,
    output logic [NUM_REQ-1:0]                  grant_o,
    output logic [$clog2(NUM_REQ)-1:0]          grant_id_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                err_o
);

    localparam int unsigned BEATS = DATA_INPUT_WIDTH / DATA_OUTPUT_WIDTH;
    localparam int unsigned IDW   = $clog2(NUM_REQ);
    // Beat counter saturates at BEATS+1, the overrun threshold.
    localparam int unsigned CW    = $clog2(BEATS + 2);
    localparam int unsigned TW    = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } state_t;

    state_t                      state_q, state_d;
    logic [DATA_INPUT_WIDTH-1:0] hold_q, hold_d;
    logic [NUM_REQ-1:0]          grant_q, grant_d;
    logic [IDW-1:0]              gid_q, gid_d;
    logic [IDW-1:0]              last_q, last_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [CW-1:0]               cnt_inc;
    logic [TW-1:0]               tmr_q, tmr_d;
    logic                        done_q, done_d;
    logic                        err_q, err_d;

    logic                        win_found;
    logic [IDW-1:0]              win_id;
    logic [NUM_REQ-1:0]          win_oh;
    int unsigned                 scan_idx;
    logic                        fin;
    logic                        fin_err;

    // Rotating-priority search: first valid requester after the last winner, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (32'(last_q) + k) % NUM_REQ;
            if (!win_found && req_valid_i[IDW'(scan_idx)]) begin
                win_found = 1'b1;
                win_id    = IDW'(scan_idx);
            end
        end
        win_oh         = '0;
        win_oh[win_id] = win_found;
    end

    assign req_ready_o = (state_q == IDLE) ? win_oh : '0;
    assign ser_valid_o = (state_q == LOAD);
    assign ser_data_o  = hold_q;
    assign grant_o     = grant_q;
    assign grant_id_o  = gid_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;

    assign cnt_inc = (cnt_q > CW'(BEATS)) ? cnt_q : cnt_q + 1'b1;

    // Next-state logic: arbitration in IDLE, load handshake with timeout, beat tracking.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        done_d  = 1'b0;
        err_d   = err_q;
        fin     = 1'b0;
        fin_err = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    hold_d  = req_data_i[win_id*DATA_INPUT_WIDTH +: DATA_INPUT_WIDTH];
                    grant_d = win_oh;
                    gid_d   = win_id;
                    last_d  = win_id;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Beats emitted while still in LOAD are counted as well.
                if (ser_busy_i) begin
                    cnt_d = cnt_inc;
                end
                if (ser_accepted_i) begin
                    state_d = DRAIN;
                end else if (tmr_q == TW'(LOAD_TIMEOUT - 1)) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (ser_busy_i) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc > CW'(BEATS)) begin
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end
                end else if (cnt_q != '0) begin
                    fin     = 1'b1;
                    fin_err = (cnt_q != CW'(BEATS));
                end
            end
            default: state_d = IDLE;
        endcase

        if (fin) begin
            done_d  = 1'b1;
            grant_d = '0;
            gid_d   = '0;
            state_d = IDLE;
            if (fin_err) begin
                err_d = 1'b1;
            end
        end
    end

    // State and datapath registers; reset leaves requester 0 first in line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            grant_q <= '0;
            gid_q   <= '0;
            last_q  <= IDW'(NUM_REQ - 1);
            cnt_q   <= '0;
            tmr_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_seq_arbiter.sv
// tb_seq_arbiter: randomized scoreboard bench for seq_arbiter with a
// behavioural serializer stub and a round-robin reference model.
module tb_seq_arbiter;

    localparam int unsigned NR    = 4;
    localparam int unsigned W     = 256;
    localparam int unsigned OW    = 32;
    localparam int unsigned BEATS = W / OW;
    localparam int unsigned LT    = 16;

    typedef struct {
        int unsigned  id;
        logic [W-1:0] data;
        bit           err;
        int unsigned  lat;
    } exp_t;

    logic              clk;
    logic              reset_n;
    logic [NR-1:0]     req_valid_i;
    logic [NR*W-1:0]   req_data_i;
    logic [NR-1:0]     req_ready_o;
    logic              ser_valid_o;
    logic [W-1:0]      ser_data_o;
    logic              ser_accepted_i;
    logic              ser_busy_i;
    logic [NR-1:0]     grant_o;
    logic [1:0]        grant_id_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    int unsigned checks;
    int unsigned failures;

    exp_t        sb[$];
    int unsigned model_last;
    bit          exp_err;

    // serializer stub state
    int unsigned  stub_mode;   // 0: accepts loads, 1: never accepts
    int unsigned  stub_len;    // cycles ser_busy_i stays high per load
    int unsigned  s_left;
    int unsigned  s_total;
    int unsigned  s_idx;
    logic [OW-1:0] s_beat;
    logic [W-1:0] s_word;
    logic [W-1:0] s_latch;
    bit           s_pend;

    seq_arbiter #(
        .NUM_REQ(NR),
        .DATA_INPUT_WIDTH(W),
        .DATA_OUTPUT_WIDTH(OW),
        .LOAD_TIMEOUT(LT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid_i(req_valid_i),
        .req_data_i(req_data_i),
        .req_ready_o(req_ready_o),
        .ser_valid_o(ser_valid_o),
        .ser_data_o(ser_data_o),
        .ser_accepted_i(ser_accepted_i),
        .ser_busy_i(ser_busy_i),
        .grant_o(grant_o),
        .grant_id_o(grant_id_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Serializer stub: latches a load seen in the previous cycle, acknowledges,
    // then holds busy for stub_len cycles presenting one beat per cycle.
    initial begin
        ser_accepted_i = 1'b0;
        ser_busy_i     = 1'b0;
        s_left = 0; s_total = 0; s_idx = 0; s_beat = '0;
        s_word = '0; s_latch = '0; s_pend = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                s_left = 0; s_pend = 1'b0;
                ser_accepted_i = 1'b0;
                ser_busy_i     = 1'b0;
                continue;
            end
            ser_accepted_i = 1'b0;
            if (s_pend) begin
                s_word  = s_latch;
                s_left  = stub_len;
                s_total = stub_len;
                s_pend  = 1'b0;
                ser_accepted_i = 1'b1;
            end
            if (s_left != 0) begin
                ser_busy_i = 1'b1;
                s_idx  = s_total - s_left;
                s_beat = (s_idx < BEATS) ? s_word[s_idx*OW +: OW] : '0;
                s_left--;
            end else begin
                ser_busy_i = 1'b0;
            end
            if (stub_mode == 0 && ser_valid_o && !ser_accepted_i && !ser_busy_i) begin
                s_pend  = 1'b1;
                s_latch = ser_data_o;
            end
        end
    end

    // Monitor: pops an expectation on every transfer and checks the transaction.
    initial begin
        int unsigned cyc;
        int unsigned xfer_cyc;
        bit          active;
        exp_t        cur;
        exp_t        e;
        cyc = 0; xfer_cyc = 0; active = 1'b0;
        cur = '{id: 0, data: '0, err: 1'b0, lat: 0};
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                active = 1'b0;
                sb.delete();
                continue;
            end
            if (done_o) begin
                chk("done_expected", active, 1'b1);
                if (active) begin
                    chk("done_latency", cyc - xfer_cyc, cur.lat);
                    chk("err_at_done", err_o, cur.err);
                    chk("grant_cleared", grant_o, '0);
                    active = 1'b0;
                end
            end
            if (active && (cyc - xfer_cyc) > 40) begin
                chk("done_timeout", cyc - xfer_cyc, cur.lat);
                active = 1'b0;
            end
            if (active && cyc == xfer_cyc + 1) begin
                chk("ser_valid", ser_valid_o, 1'b1);
                chk("load_data", ser_data_o, cur.data);
                chk("grant", grant_o, 256'(1) << cur.id);
                chk("grant_id", grant_id_o, cur.id);
                chk("busy", busy_o, 1'b1);
            end
            if (active && ser_busy_i && s_idx < BEATS) begin
                chk("beat", s_beat, cur.data[s_idx*OW +: OW]);
            end
            if ((req_valid_i & req_ready_o) != '0) begin
                chk("xfer_overlap", active, 1'b0);
                chk("idle_busy", busy_o, 1'b0);
                if (sb.size() == 0) begin
                    chk("xfer_unexpected", req_ready_o, '0);
                end else begin
                    e = sb.pop_front();
                    chk("winner", req_ready_o, 256'(1) << e.id);
                    cur      = e;
                    xfer_cyc = cyc;
                    active   = 1'b1;
                end
            end
            if (busy_o) begin
                chk("ready_while_busy", req_ready_o, '0);
            end
        end
    end

    // Reference: serve the pending set in rotating order after the last winner.
    task automatic run_round(input logic [NR-1:0] mask, input int unsigned mode,
                             input int unsigned blen, input bit fixed);
        logic [W-1:0]  d[NR];
        logic [NR-1:0] rem;
        logic [NR-1:0] served;
        int unsigned   p;
        int unsigned   idx;
        int unsigned   n;
        bit            found;
        exp_t          e;
        for (int unsigned i = 0; i < NR; i++) begin
            for (int unsigned j = 0; j < W / 32; j++) begin
                d[i][j*32 +: 32] = $urandom();
            end
            if (fixed) begin
                for (int unsigned b = 0; b < W / 8; b++) begin
                    d[i][b*8 +: 8] = 8'(b + 1);
                end
            end
        end
        stub_mode = mode;
        stub_len  = blen;
        rem = mask;
        p   = model_last;
        while (rem != '0) begin
            found = 1'b0;
            idx   = 0;
            for (int unsigned k = 1; k <= NR; k++) begin
                if (!found && rem[(p + k) % NR]) begin
                    found = 1'b1;
                    idx   = (p + k) % NR;
                end
            end
            if (mode == 1 || blen != BEATS) exp_err = 1'b1;
            e.id   = idx;
            e.data = d[idx];
            e.err  = exp_err;
            e.lat  = (mode == 1) ? LT + 1 : ((blen > BEATS) ? BEATS + 3 : blen + 3);
            sb.push_back(e);
            rem[idx] = 1'b0;
            p = idx;
        end
        model_last = p;

        @(posedge clk);
        #1;
        for (int unsigned i = 0; i < NR; i++) begin
            if (mask[i]) req_data_i[i*W +: W] = d[i];
        end
        req_valid_i = mask;
        n = 0;
        while (req_valid_i != '0 && n < 200) begin
            @(negedge clk);
            served = req_valid_i & req_ready_o;
            @(posedge clk);
            #1;
            req_valid_i = req_valid_i & ~served;
            n++;
        end
        chk("round_served", req_valid_i, '0);
        req_valid_i = '0;
        n = 0;
        while (busy_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("round_idle", busy_o, 1'b0);
        n = 0;
        while (s_left != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_grant"}, grant_o, '0);
        chk({tag, "_grant_id"}, grant_id_o, '0);
        chk({tag, "_done"}, done_o, 1'b0);
        chk({tag, "_err"}, err_o, 1'b0);
        chk({tag, "_ser_valid"}, ser_valid_o, 1'b0);
        chk({tag, "_ser_data"}, ser_data_o, '0);
        chk({tag, "_ready"}, req_ready_o, '0);
    endtask

    // Stimulus: directed rounds, random rounds, error modes, reset mid-drain.
    initial begin
        logic [NR-1:0] m;
        logic [NR-1:0] served;
        logic [W-1:0]  rd;
        int unsigned   n;
        checks = 0; failures = 0;
        reset_n = 1'b0;
        req_valid_i = '0;
        req_data_i  = '0;
        stub_mode = 0; stub_len = BEATS;
        exp_err = 1'b0;
        model_last = NR - 1;
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;

        run_round(4'b0001, 0, BEATS, 1'b1);
        run_round(4'b1111, 0, BEATS, 1'b0);
        run_round(4'b1111, 0, BEATS, 1'b0);
        run_round(4'b1000, 0, BEATS, 1'b0);
        run_round(4'b0100, 0, BEATS, 1'b0);
        run_round(4'b0101, 0, BEATS, 1'b0);
        for (int r = 0; r < 6; r++) begin
            m = 4'($urandom_range(15, 1));
            run_round(m, 0, BEATS, 1'b0);
        end
        chk("err_clean", err_o, 1'b0);

        run_round(4'b0011, 1, BEATS, 1'b0);   // load timeout
        run_round(4'b0110, 0, BEATS, 1'b0);   // arbitration continues after timeout
        run_round(4'b0110, 0, 5, 1'b0);       // short busy window
        run_round(4'b0001, 0, 12, 1'b0);      // busy overrun

        // reset while draining
        rd = '0;
        for (int unsigned j = 0; j < W / 32; j++) rd[j*32 +: 32] = $urandom();
        stub_mode = 0; stub_len = BEATS;
        sb.push_back('{id: 2, data: rd, err: exp_err, lat: BEATS + 3});
        @(posedge clk);
        #1;
        req_data_i[2*W +: W] = rd;
        req_valid_i = 4'b0100;
        served = '0;
        n = 0;
        while (served == '0 && n < 20) begin
            @(negedge clk);
            served = req_valid_i & req_ready_o;
            n++;
        end
        chk("rst_xfer", served, 4'b0100);
        @(posedge clk);
        #1;
        req_valid_i = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("pre_reset_busy", busy_o, 1'b1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        model_last = NR - 1;
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;

        run_round(4'b1111, 0, BEATS, 1'b0);
        chk("err_after_reset", err_o, 1'b0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit");
    end

endmodule
